// File: rtl/reg_counter_pkg.sv
// Shared encodings for the register counter bank.
//   mode_e   : per-fire update mode (count, transfer, ALU write-back, clear)
//   alu_op_e : ALU operation applied to the two selected operands
package reg_counter_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'b00,
    MODE_XFER  = 2'b01,
    MODE_ALU   = 2'b10,
    MODE_CLR   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/rc_alu.sv
// Combinational ALU shared by every ALU-mode destination of the bank.
// Ports:
//   a, b   : WIDTH-bit operands
//   op     : OP_ADD / OP_SUB / OP_AND / OP_OR
//   result : WIDTH-bit result (add/sub wrap)
//   carry  : carry-out on add, borrow (a < b) on sub, 0 on and/or
module rc_alu
  import reg_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  // The extra top bit of the extended subtraction is set exactly when a < b.
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  {carry, result} = w_sum;
      OP_SUB:  {carry, result} = w_diff;
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase
  end

endmodule

// File: rtl/reg_counter_bank.sv
// Bank of NUM_REGS registers, each updated once per rising edge of its own
// load request. The update applied is chosen by mode: count (per-register
// direction, wrap or saturate), transfer from another register, ALU
// write-back, or clear.
// Ports:
//   clk, RST   : clock, asynchronous active-high reset
//   load_req   : per-register level request, rising edge fires one update
//   mode       : 00 count, 01 transfer, 10 ALU, 11 clear
//   dir        : per-register count direction (1 = decrement)
//   src_sel    : transfer source / mux_out select
//   alu_a_sel, alu_b_sel, alu_op : ALU operand selects and operation
//   regs_flat  : register i on [i*WIDTH +: WIDTH]
//   mux_out    : combinational value of register src_sel (0 if out of range)
//   carry_flag, zero_flag : flags of the last ALU write-back
//   upd_valid  : pulse in the cycle following any register update
module reg_counter_bank
  import reg_counter_pkg::*;
#(
  parameter int  NUM_REGS = 3,
  parameter int  WIDTH    = 4,
  parameter bit  SAT      = 1'b0,
  localparam int SELW     = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [NUM_REGS-1:0]       load_req,
  input  logic [1:0]                mode,
  input  logic [NUM_REGS-1:0]       dir,
  input  logic [SELW-1:0]           src_sel,
  input  logic [SELW-1:0]           alu_a_sel,
  input  logic [SELW-1:0]           alu_b_sel,
  input  logic [1:0]                alu_op,
  output logic [NUM_REGS*WIDTH-1:0] regs_flat,
  output logic [WIDTH-1:0]          mux_out,
  output logic                      carry_flag,
  output logic                      zero_flag,
  output logic                      upd_valid
);

  logic [WIDTH-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_load_q;
  logic                r_carry;
  logic                r_zero;
  logic                r_upd;

  logic [NUM_REGS-1:0] w_fire;
  logic [WIDTH-1:0]    w_src;
  logic [WIDTH-1:0]    w_a;
  logic [WIDTH-1:0]    w_b;
  logic [WIDTH-1:0]    w_alu_res;
  logic                w_alu_carry;
  logic [WIDTH-1:0]    w_next [NUM_REGS];

  assign w_fire = load_req & ~r_load_q;

  // Decode by matching each legal index, so an index >= NUM_REGS falls
  // through to 0 without ever addressing past the array.
  always_comb begin
    w_src = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_sel == SELW'(i))   w_src = r_regs[i];
      if (alu_a_sel == SELW'(i)) w_a   = r_regs[i];
      if (alu_b_sel == SELW'(i)) w_b   = r_regs[i];
    end
  end

  rc_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (w_a),
    .b      (w_b),
    .op     (alu_op),
    .result (w_alu_res),
    .carry  (w_alu_carry)
  );

  // Next values are built purely from current register contents, so all
  // registers firing together see pre-update operands.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_next[i] = r_regs[i];
      case (mode)
        MODE_COUNT: begin
          if (dir[i]) begin
            if (!(SAT && (r_regs[i] == '0))) w_next[i] = r_regs[i] - WIDTH'(1);
          end else begin
            if (!(SAT && (r_regs[i] == '1))) w_next[i] = r_regs[i] + WIDTH'(1);
          end
        end
        MODE_XFER: w_next[i] = w_src;
        MODE_ALU:  w_next[i] = w_alu_res;
        default:   w_next[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      // History resets to ones so a request already high at release is
      // treated as old and does not fire.
      r_load_q <= '1;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_upd    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_load_q <= load_req;
      r_upd    <= |w_fire;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_fire[i]) r_regs[i] <= w_next[i];
      end
      if ((|w_fire) && (mode == MODE_ALU)) begin
        r_carry <= w_alu_carry;
        r_zero  <= (w_alu_res == '0);
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
  end

  assign mux_out    = w_src;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign upd_valid  = r_upd;

endmodule

// File: tb/tb_reg_counter_bank.sv
// Bench for reg_counter_bank: two instances (wrap and saturate) share the
// same stimulus and are checked against an arithmetic reference model.
module tb_reg_counter_bank;
  import reg_counter_pkg::*;

  logic        clk = 1'b0;
  logic        RST;
  logic [2:0]  load_req, dir;
  logic [1:0]  mode, src_sel, alu_a, alu_b, alu_op;
  logic [23:0] flat_w, flat_s;
  logic [7:0]  mux_w, mux_s;
  logic        cf_w, cf_s, zf_w, zf_s, upd_w, upd_s;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: [0] = wrap instance, [1] = saturating instance
  int m [2][3];
  bit mc [2];
  bit mz [2];

  logic [1:0]  obs_hi, obs_mid, obs_lo;
  logic [15:0] obs_r0_hi;

  always #5 clk = ~clk;

  reg_counter_bank #(.NUM_REGS(3), .WIDTH(8), .SAT(1'b0)) dut_w (
    .clk(clk), .RST(RST), .load_req(load_req), .mode(mode), .dir(dir),
    .src_sel(src_sel), .alu_a_sel(alu_a), .alu_b_sel(alu_b), .alu_op(alu_op),
    .regs_flat(flat_w), .mux_out(mux_w), .carry_flag(cf_w), .zero_flag(zf_w),
    .upd_valid(upd_w));

  reg_counter_bank #(.NUM_REGS(3), .WIDTH(8), .SAT(1'b1)) dut_s (
    .clk(clk), .RST(RST), .load_req(load_req), .mode(mode), .dir(dir),
    .src_sel(src_sel), .alu_a_sel(alu_a), .alu_b_sel(alu_b), .alu_op(alu_op),
    .regs_flat(flat_s), .mux_out(mux_s), .carry_flag(cf_s), .zero_flag(zf_s),
    .upd_valid(upd_s));

  function automatic logic [7:0] dreg(input int k, input int i);
    return (k == 0) ? flat_w[i*8 +: 8] : flat_s[i*8 +: 8];
  endfunction

  function automatic logic [7:0] dmux(input int k);
    return (k == 0) ? mux_w : mux_s;
  endfunction

  function automatic logic [1:0] dflags(input int k);
    return (k == 0) ? {cf_w, zf_w} : {cf_s, zf_s};
  endfunction

  function automatic int mux_exp(input int k);
    return (int'(src_sel) < 3) ? m[k][int'(src_sel)] : 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) m[k][i] = 0;
      mc[k] = 1'b0;
      mz[k] = 1'b0;
    end
  endtask

  // Applies one update event (rising edge on the registers in mask).
  task automatic model_apply(input logic [2:0] mask);
    int old [3];
    int av, bv, res, v, s, ia, ib;
    bit cy;
    s  = int'(src_sel);
    ia = int'(alu_a);
    ib = int'(alu_b);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) old[i] = m[k][i];
      av = (ia < 3) ? old[ia] : 0;
      bv = (ib < 3) ? old[ib] : 0;
      cy = 1'b0;
      case (alu_op)
        OP_ADD:  begin res = av + bv; cy = (res > 255); end
        OP_SUB:  begin res = av - bv; cy = (av < bv); end
        OP_AND:  res = av & bv;
        default: res = av | bv;
      endcase
      res = res & 255;
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          case (mode)
            MODE_COUNT: begin
              if (!dir[i]) v = (old[i] == 255) ? ((k == 1) ? 255 : 0) : old[i] + 1;
              else         v = (old[i] == 0)   ? ((k == 1) ? 0 : 255)  : old[i] - 1;
            end
            MODE_XFER: v = (s < 3) ? old[s] : 0;
            MODE_ALU:  v = res;
            default:   v = 0;
          endcase
          m[k][i] = v;
        end
      end
      if (mask != 3'b000 && mode == MODE_ALU) begin
        mc[k] = cy;
        mz[k] = (res == 0);
      end
    end
  endtask

  // Raises load_req for hold cycles then drops it for one cycle.
  task automatic fire(input logic [2:0] mask, input int hold, input bit scramble);
    load_req = mask;
    model_apply(mask);
    @(negedge clk);
    obs_hi    = {upd_s, upd_w};
    obs_r0_hi = {flat_s[7:0], flat_w[7:0]};
    obs_mid   = 2'b00;
    for (int h = 1; h < hold; h++) begin
      if (scramble) begin
        mode    = 2'($urandom_range(0, 3));
        src_sel = 2'($urandom_range(0, 3));
        alu_a   = 2'($urandom_range(0, 3));
        alu_b   = 2'($urandom_range(0, 3));
        alu_op  = 2'($urandom_range(0, 3));
        dir     = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      obs_mid = obs_mid | {upd_s, upd_w};
    end
    load_req = 3'b000;
    @(negedge clk);
    obs_lo = {upd_s, upd_w};
  endtask

  task automatic set_reg(input int idx, input int val);
    mode = MODE_CLR;
    fire(3'(1 << idx), 1, 1'b0);
    mode = MODE_COUNT;
    dir  = 3'b000;
    repeat (val) fire(3'(1 << idx), 1, 1'b0);
  endtask

  task automatic test_reset();
    RST = 1'b1; load_req = 3'b111; mode = MODE_COUNT; dir = 3'b000;
    src_sel = 2'd0; alu_a = 2'd0; alu_b = 2'd0; alu_op = OP_ADD;
    model_clear();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({dflags(k), (k == 0) ? upd_w : upd_s} !== 3'b000 ||
          ((k == 0) ? flat_w : flat_s) !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d flags/upd=%b regs=%h exp 0", k,
                 {dflags(k), (k == 0) ? upd_w : upd_s}, (k == 0) ? flat_w : flat_s);
      end
    end
    @(negedge clk);
    RST = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (flat_w !== 24'h0 || flat_s !== 24'h0 || {upd_s, upd_w} !== 2'b00) begin
        n_fail++;
        $display("FAIL held_at_release regs=%h/%h upd=%b exp 0", flat_w, flat_s, {upd_s, upd_w});
      end
    end
    load_req = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_single_fire();
    mode = MODE_COUNT; dir = 3'b000;
    fire(3'b001, 5, 1'b0);
    n_checks++;
    if (obs_r0_hi !== {8'd1, 8'd1}) begin
      n_fail++; $display("FAIL single_latency r0=%h exp 0101", obs_r0_hi);
    end
    n_checks++;
    if (obs_hi !== 2'b11 || obs_mid !== 2'b00 || obs_lo !== 2'b00) begin
      n_fail++; $display("FAIL single_upd hi=%b mid=%b lo=%b exp 11/00/00", obs_hi, obs_mid, obs_lo);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dreg(k, 0) !== 8'(m[k][0]) || dreg(k, 0) !== 8'd1) begin
        n_fail++; $display("FAIL single_hold dut%0d r0=%h exp 01", k, dreg(k, 0));
      end
    end
  endtask

  task automatic test_wrap_sat();
    set_reg(1, 255);
    mode = MODE_COUNT; dir = 3'b000;
    fire(3'b010, 1, 1'b0);
    n_checks++;
    if (dreg(0, 1) !== 8'h00 || dreg(1, 1) !== 8'hFF) begin
      n_fail++; $display("FAIL inc_limit wrap=%h sat=%h exp 00/FF", dreg(0, 1), dreg(1, 1));
    end
    mode = MODE_CLR;
    fire(3'b010, 1, 1'b0);
    mode = MODE_COUNT; dir = 3'b010;
    fire(3'b010, 1, 1'b0);
    n_checks++;
    if (dreg(0, 1) !== 8'hFF || dreg(1, 1) !== 8'h00) begin
      n_fail++; $display("FAIL dec_limit wrap=%h sat=%h exp FF/00", dreg(0, 1), dreg(1, 1));
    end
  endtask

  task automatic test_alu();
    logic [2:0] masks [6];
    logic [1:0] ops [6];
    logic [1:0] asel [6];
    logic [1:0] bsel [6];
    logic [1:0] modes [6];
    masks = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b011};
    ops   = '{OP_ADD, OP_SUB, OP_AND, OP_AND, OP_OR,  OP_ADD};
    asel  = '{2'd0,   2'd1,   2'd0,   2'd3,   2'd0,   2'd0};
    bsel  = '{2'd1,   2'd0,   2'd1,   2'd1,   2'd1,   2'd1};
    modes = '{MODE_ALU, MODE_ALU, MODE_ALU, MODE_ALU, MODE_COUNT, MODE_ALU};
    mode = MODE_CLR;
    fire(3'b111, 1, 1'b0);
    set_reg(0, 8'hF0);
    set_reg(1, 8'h20);
    for (int t = 0; t < 6; t++) begin
      mode = modes[t]; alu_op = ops[t]; alu_a = asel[t]; alu_b = bsel[t]; dir = 3'b000;
      fire(masks[t], 1, 1'b0);
      if (t == 0) begin
        n_checks++;
        if (dreg(0, 2) !== 8'h10 || {cf_w, zf_w} !== 2'b10) begin
          n_fail++; $display("FAIL alu_add r2=%h cz=%b exp 10/10", dreg(0, 2), {cf_w, zf_w});
        end
      end
      if (t == 1) begin
        n_checks++;
        if (dreg(0, 2) !== 8'h30 || cf_w !== 1'b1) begin
          n_fail++; $display("FAIL alu_sub r2=%h c=%b exp 30/1", dreg(0, 2), cf_w);
        end
      end
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (dreg(k, i) !== 8'(m[k][i])) begin
            n_fail++; $display("FAIL alu_regs t%0d dut%0d R%0d got %h exp %h", t, k, i, dreg(k, i), 8'(m[k][i]));
          end
        end
        n_checks++;
        if (dflags(k) !== {mc[k], mz[k]}) begin
          n_fail++; $display("FAIL alu_flags t%0d dut%0d got %b exp %b", t, k, dflags(k), {mc[k], mz[k]});
        end
      end
    end
  endtask

  task automatic test_transfer();
    set_reg(0, 5);
    set_reg(1, 9);
    mode = MODE_XFER; src_sel = 2'd1;
    fire(3'b011, 1, 1'b0);
    n_checks++;
    if (dreg(0, 0) !== 8'd9 || dreg(0, 1) !== 8'd9) begin
      n_fail++; $display("FAIL xfer_simul r0=%h r1=%h exp 09/09", dreg(0, 0), dreg(0, 1));
    end
    src_sel = 2'd0;
    fire(3'b010, 1, 1'b0);
    src_sel = 2'd1;
    fire(3'b010, 1, 1'b0);
    n_checks++;
    if (obs_hi !== 2'b11) begin
      n_fail++; $display("FAIL xfer_self_upd got %b exp 11", obs_hi);
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (dreg(k, i) !== 8'(m[k][i])) begin
          n_fail++; $display("FAIL xfer_regs dut%0d R%0d got %h exp %h", k, i, dreg(k, i), 8'(m[k][i]));
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int s = 0; s < 4; s++) begin
      src_sel = 2'(s);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dmux(k) !== 8'(mux_exp(k))) begin
          n_fail++; $display("FAIL mux_sel%0d dut%0d got %h exp %h", s, k, dmux(k), 8'(mux_exp(k)));
        end
      end
    end
    @(negedge clk);
    mode = MODE_XFER; src_sel = 2'd3;
    fire(3'b001, 1, 1'b0);
    n_checks++;
    if (dreg(0, 0) !== 8'h00 || dreg(1, 0) !== 8'h00) begin
      n_fail++; $display("FAIL oor_xfer r0=%h/%h exp 00", dreg(0, 0), dreg(1, 0));
    end
  endtask

  task automatic test_async_reset();
    set_reg(0, 7);
    @(negedge clk);
    mode = MODE_COUNT; dir = 3'b000; load_req = 3'b001;
    #2 RST = 1'b1;
    #1;
    model_clear();
    n_checks++;
    if (flat_w !== 24'h0 || flat_s !== 24'h0 || {cf_w, zf_w, cf_s, zf_s, upd_w, upd_s} !== 6'b0) begin
      n_fail++; $display("FAIL async_reset regs=%h/%h flags=%b exp 0", flat_w, flat_s,
                         {cf_w, zf_w, cf_s, zf_s, upd_w, upd_s});
    end
    repeat (2) @(negedge clk);
    RST = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (flat_w !== 24'h0 || flat_s !== 24'h0 || {upd_s, upd_w} !== 2'b00) begin
        n_fail++; $display("FAIL rst_release_hold regs=%h/%h upd=%b exp 0", flat_w, flat_s, {upd_s, upd_w});
      end
    end
    load_req = 3'b000;
    @(negedge clk);
    fire(3'b001, 1, 1'b0);
    n_checks++;
    if (dreg(0, 0) !== 8'd1 || dreg(1, 0) !== 8'd1 || obs_hi !== 2'b11) begin
      n_fail++; $display("FAIL refire_after_rst r0=%h/%h upd=%b exp 01/01/11", dreg(0, 0), dreg(1, 0), obs_hi);
    end
  endtask

  task automatic test_random();
    logic [2:0] mask;
    for (int it = 0; it < 150; it++) begin
      mode    = 2'($urandom_range(0, 3));
      dir     = 3'($urandom_range(0, 7));
      src_sel = 2'($urandom_range(0, 3));
      alu_a   = 2'($urandom_range(0, 3));
      alu_b   = 2'($urandom_range(0, 3));
      alu_op  = 2'($urandom_range(0, 3));
      mask    = 3'($urandom_range(0, 7));
      fire(mask, $urandom_range(1, 3), 1'b1);
      n_checks++;
      if (obs_hi !== ((mask != 3'b000) ? 2'b11 : 2'b00) || obs_mid !== 2'b00 || obs_lo !== 2'b00) begin
        n_fail++; $display("FAIL rand_upd it%0d mask=%b hi=%b mid=%b lo=%b", it, mask, obs_hi, obs_mid, obs_lo);
      end
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (dreg(k, i) !== 8'(m[k][i])) begin
            n_fail++; $display("FAIL rand_regs it%0d dut%0d R%0d got %h exp %h", it, k, i, dreg(k, i), 8'(m[k][i]));
          end
        end
        n_checks++;
        if (dflags(k) !== {mc[k], mz[k]} || dmux(k) !== 8'(mux_exp(k))) begin
          n_fail++; $display("FAIL rand_flags_mux it%0d dut%0d cz=%b mux=%h exp %b/%h", it, k,
                             dflags(k), dmux(k), {mc[k], mz[k]}, 8'(mux_exp(k)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fire();
    test_wrap_sat();
    test_alu();
    test_transfer();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
